// File: rtl/seq_pkg.sv
// Shared encodings and the default code table for the programmable sequence counter.
package seq_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic DIR_FWD      = 1'b0;
    localparam logic DIR_REV      = 1'b1;
    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    // Standard 8-step arbitrary sequence; entries beyond it default to zero.
    function automatic logic [3:0] default_code(input int unsigned i);
        case (i)
            0:       return 4'b0000;
            1:       return 4'b1101;
            2:       return 4'b1011;
            3:       return 4'b1001;
            4:       return 4'b0110;
            5:       return 4'b1100;
            6:       return 4'b0011;
            7:       return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/seq_table.sv
// DEPTH x WIDTH code table: synchronous write, asynchronous read, clr restores defaults.
module seq_table
    import seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // A clear in the same cycle as a write drops the write.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= WIDTH'(default_code(i));
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/seq_counter_prog.sv
// Programmable sequence counter: steps an index through a loadable code table.
module seq_counter_prog
    import seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic [AW-1:0]    len_m1,
    input  logic             load,
    input  logic [AW-1:0]    load_idx,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] q,
    output logic [AW-1:0]    idx,
    output logic             tc,
    output logic             done
);

    state_t           state, state_next;
    logic [AW-1:0]    idx_next;
    logic [WIDTH-1:0] rd_data;

    seq_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .clk     (clk),
        .clr     (clr),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (idx_next),
        .rd_data (rd_data)
    );

    assign tc   = (dir == DIR_FWD) ? (idx >= len_m1) : (idx == '0);
    assign done = (state == ST_HALT);

    always_comb begin
        idx_next   = idx;
        state_next = state;
        if (load) begin
            idx_next   = (load_idx > len_m1) ? len_m1 : load_idx;
            state_next = ST_RUN;
        end else if (en && state == ST_RUN) begin
            if (!tc) begin
                idx_next = (dir == DIR_FWD) ? idx + 1'b1 : idx - 1'b1;
            end else if (mode == MODE_WRAP) begin
                idx_next = (dir == DIR_FWD) ? '0 : len_m1;
            end else begin
                state_next = ST_HALT;
            end
        end
    end

    // The table still holds pre-clear contents during clr, so q is forced to the default.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ST_RUN;
            idx   <= '0;
            q     <= WIDTH'(default_code(0));
        end else begin
            state <= state_next;
            idx   <= idx_next;
            q     <= (wr_en && wr_addr == idx_next) ? wr_data : rd_data;
        end
    end

endmodule

// File: doc/seq_counter_prog.md
# seq_counter_prog

Programmable, parametrised sequence counter. It steps through a run-time loadable table of WIDTH-bit codes instead of a hard-wired code chain. It adds the following:
- forward/reverse direction
- programmable sequence length
- wrap or one-shot mode
- direct index load
- terminal-count and done flags

It is the general-purpose replacement for fixed arbitrary-sequence counters in the Counter/Synchronous family. Its reset table reproduces the standard 8-step sequence 0000→1101→1011→1001→0110→1100→0011→1111.

## Interface
Parameters:
- WIDTH, 4, bits per sequence code
- DEPTH, 8, table entries (power of two, ≥2)
- AW, $clog2(DEPTH), index width (derived, do not override)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- clr  in  1  reset: one clock; reset is synchronous and active-high
- en  in  1  advance one step this cycle
- dir  in  1  0 = forward (idx+1), 1 = reverse (idx−1)
- mode  in  1  0 = wrap, 1 = one-shot
- len_m1  in  AW  active sequence length minus 1
- load  in  1  jump to load_idx
- load_idx  in  AW  target index
- wr_en  in  1  table write strobe
- wr_addr  in  AW  table write address
- wr_data  in  WIDTH  table write data
- q  out  WIDTH  current code, registered
- idx  out  AW  current table index, registered
- tc  out  1  terminal position for current dir/len_m1, combinational
- done  out  1  one-shot completed, registered

## Operation
- Reset (clr=1 at an edge):
  - idx=0, q=table default[0]=0000, done=0, state=RUN.
  - The table reloads defaults: 0000, 1101, 1011, 1001, 0110, 1100, 0011, 1111, and 0 for any entries beyond 8 (when WIDTH/DEPTH are larger, codes are zero-extended).
- Priority per edge: clr > load > step (en) > hold.
- States:
  - RUN: normal stepping.
  - HALT: one-shot finished.
- RUN, en=1:
  - If tc=0: idx_next = idx±1.
  - If tc=1 and mode=0: wrap. Forward goes to 0; reverse goes to len_m1.
  - If tc=1 and mode=1: idx holds, state→HALT, done←1.
- HALT:
  - en is ignored; q and idx hold.
  - load or clr returns the block to RUN with done←0.
- load:
  - idx_next = min(load_idx, len_m1). This is legal in both states.
  - load with en=1 performs the load only; the step is discarded.
- tc:
  - Forward: idx ≥ len_m1.
  - Reverse: idx == 0.
  - Consequence: if len_m1 is lowered below the current idx, the next forward step wraps to 0 (or halts in one-shot mode).
- len_m1=0 gives a 1-entry sequence: tc is constantly 1, and wrap holds at idx 0.
- q update: every edge, q ← table[idx_next].
- Write-first bypass: if wr_en and wr_addr == idx_next in the same cycle, q ← wr_data.
- A table write to any other address never disturbs q.
- dir and mode changes take effect on the same edge they are sampled; no pipeline.

## Timing
- Step latency: en high at edge N → idx/q show the new entry after edge N.
- Load latency: one edge.
- Table write is visible to a subsequent step one edge after wr_en.
- done asserts on the same edge idx stops at the terminal entry, and stays high until load or clr.
- tc is combinational from idx, dir and len_m1, with no registered delay.
- clr mid-sequence or mid-write: the reset wins, and the write is dropped (the table returns to defaults).
- Throughput: one step per cycle, sustained.

## Structure
- Shared package seq_pkg holds:
  - state encoding localparams ST_RUN=1'b0, ST_HALT=1'b1
  - default-table constant function/array, indexed by entry
  - the DIR_FWD/DIR_REV and MODE_WRAP/MODE_ONESHOT encodings
- Sub-module seq_table:
  - DEPTH×WIDTH register file
  - synchronous write, asynchronous read
  - synchronous clr to defaults
  - read port driven by idx_next
- The top holds the idx register, state register, next-index logic, bypass mux and flags.

## Test plan
- Reset, then en=1, dir=0, mode=0, len_m1=7, for 9 cycles → q = 1101, 1011, 1001, 0110, 1100, 0011, 1111, 0000, 1101; tc high only while idx=7.
- dir=1 from idx=0 with len_m1=7 → idx=7, q=1111; then idx=6, q=0011.
- mode=1, len_m1=3, start idx 0, en held → idx stops at 3, q=1001, done=1 from that edge; further en has no effect; load with load_idx=1 → idx=1, q=1101, done=0.
- wr_en with wr_addr=2, wr_data=1010 while stepping from idx 1 to 2 → q=1010 on that edge (bypass); a later wrap back to idx 2 also gives 1010.
- len_m1 reduced from 7 to 2 while idx=5, forward en → idx=0, q=0000; load_idx=6 with len_m1=2 → idx=2.
- clr during HALT with a simultaneous wr_en → idx=0, q=0000, done=0, entry at wr_addr holds its default.
